// File: rtl/serial_cmp_pkg.sv
// Types shared by the MSB-first serializer and the downstream comparator
// result-capture logic.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/serial_operand_serializer_msb_first.sv
// Turns a parallel operand pair into two MSB-first bit streams, preceded by a
// one-cycle comparator clear strobe and tagged with a last-bit marker.
module serial_operand_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_clear,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_t       state_r;
  ser_state_t       state_nxt_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;
  logic             xfer_s;
  logic             load_s;

  // The counter only reaches zero on the final SHIFT cycle, so that is the
  // only point besides IDLE where a new pair can be taken.
  assign last_s   = (state_r == SHIFT) && (cnt_r == CNT_ZERO);
  assign in_ready = !rst && ((state_r == IDLE) || last_s);
  assign xfer_s   = in_valid && in_ready;

  // Next-state selection and output decode from registered state
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ser_clear   = 1'b0;
    ser_valid   = 1'b0;
    ser_a       = 1'b0;
    ser_b       = 1'b0;
    ser_last    = 1'b0;
    busy        = 1'b1;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (xfer_s) begin
          load_s      = 1'b1;
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        ser_clear   = 1'b1;
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_a     = sa_r[WIDTH-1];
        ser_b     = sb_r[WIDTH-1];
        ser_last  = last_s;
        if (last_s && xfer_s) begin
          load_s      = 1'b1;
          state_nxt_s = CLEAR;
        end else if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, bit counter and operand shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        sa_r <= in_a;
        sb_r <= in_b;
      end else if (state_r == SHIFT) begin
        sa_r <= {sa_r[WIDTH-2:0], 1'b0};
        sb_r <= {sb_r[WIDTH-2:0], 1'b0};
      end else begin
        sa_r <= sa_r;
        sb_r <= sb_r;
      end
      if (state_r == CLEAR) begin
        cnt_r <= CNT_TOP;
      end else if ((state_r == SHIFT) && !last_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer_msb_first.sv
// Scoreboard bench: an 8-bit and a 2-bit serializer, each checked against a
// word-level model of the clear / MSB-first bits / last-marker sequence.
module tb_serial_operand_serializer_msb_first;

  localparam int W  = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         ser_clear, ser_valid, ser_a, ser_b, ser_last, busy;

  logic          rst2, in_valid2, in_ready2;
  logic [W2-1:0] in_a2, in_b2;
  logic          ser_clear2, ser_valid2, ser_a2, ser_b2, ser_last2, busy2;

  serial_operand_serializer_msb_first #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ser_clear(ser_clear), .ser_valid(ser_valid),
    .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last), .busy(busy)
  );

  serial_operand_serializer_msb_first #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .ser_clear(ser_clear2), .ser_valid(ser_valid2),
    .ser_a(ser_a2), .ser_b(ser_b2), .ser_last(ser_last2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level expectation: the pair and the edge index of its transfer + 1,
  // i.e. the cycle counter value during which the clear strobe must appear.
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; int tag; } word_t;
  word_t q8[$];

  typedef struct { int cyc; logic clr; logic vld; logic a; logic b; logic last; } ev_t;
  ev_t q2[$];

  bit mon8 = 1'b0, mon2 = 1'b0, done2 = 1'b0;

  // ---------------- 8-bit driver ----------------
  task automatic drive8(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic r, output bit got, output int tag);
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b;
    #1;
    got = v && !r && in_ready;
    tag = cyc + 1;
    if (got) q8.push_back('{a: a, b: b, tag: tag});
  endtask

  task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, output int tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) drive8(1'b1, a, b, 1'b0, got, tag);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send8_timeout: pair %h/%h not accepted within 40 cycles", a, b);
    end
  endtask

  task automatic idle8();
    bit g; int t;
    drive8(1'b0, W'($urandom), W'($urandom), 1'b0, g, t);
  endtask

  bit active8 = 1'b0;

  task automatic drain8();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      idle8();
      ok = (q8.size() == 0) && !active8 && !busy;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain8_timeout: queue=%0d active=%0d busy=%0d", q8.size(), active8, busy);
    end
  endtask

  // ---------------- 8-bit monitor ----------------
  int    bitpos8 = 0;
  bit    expect_idle8 = 1'b0;
  bit    exp_clear8, exp_rdy8, exp_busy8;
  word_t cur8;

  always begin
    @(negedge clk);
    #2;
    if (mon8) begin
      exp_clear8 = (q8.size() > 0) && (q8[0].tag == cyc);
      exp_rdy8   = !rst && ((!active8 && !exp_clear8) || (active8 && bitpos8 == W-1));
      exp_busy8  = active8 || exp_clear8;
      chk("in_ready", in_ready, exp_rdy8);
      chk("busy", busy, exp_busy8);
      chk("ser_clear", ser_clear, exp_clear8);
      if (!ser_valid) chk("mask", {ser_a, ser_b, ser_last}, 3'b000);
      if (expect_idle8) begin
        chk("post_rst_idle", {ser_clear, ser_valid, ser_a, ser_b, ser_last, busy}, 6'b000000);
        expect_idle8 = 1'b0;
      end
      if (exp_clear8) begin
        cur8    = q8.pop_front();
        active8 = 1'b1;
        bitpos8 = 0;
      end else if (active8) begin
        chk("ser_valid", ser_valid, 1'b1);
        chk("ser_a", ser_a, cur8.a[W-1-bitpos8]);
        chk("ser_b", ser_b, cur8.b[W-1-bitpos8]);
        chk("ser_last", ser_last, bitpos8 == W-1);
        if (bitpos8 == W-1) active8 = 1'b0;
        bitpos8++;
      end else begin
        chk("ser_valid_idle", ser_valid, 1'b0);
      end
      if (rst) begin
        active8      = 1'b0;
        expect_idle8 = 1'b1;
      end
    end
  end

  // ---------------- 2-bit driver and monitor ----------------
  task automatic drive2(input logic v, input logic [W2-1:0] a, input logic [W2-1:0] b,
                        input logic r, output bit got, output int tag);
    @(negedge clk);
    rst2 = r; in_valid2 = v; in_a2 = a; in_b2 = b;
    #1;
    got = v && !r && in_ready2;
    tag = cyc + 1;
    if (got) begin
      q2.push_back('{cyc: tag,     clr: 1'b1, vld: 1'b0, a: 1'b0, b: 1'b0, last: 1'b0});
      q2.push_back('{cyc: tag + 1, clr: 1'b0, vld: 1'b1, a: a[1], b: b[1], last: 1'b0});
      q2.push_back('{cyc: tag + 2, clr: 1'b0, vld: 1'b1, a: a[0], b: b[0], last: 1'b1});
    end
  endtask

  task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b, output int tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) drive2(1'b1, a, b, 1'b0, got, tag);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send2_timeout: pair %b/%b not accepted within 20 cycles", a, b);
    end
  endtask

  ev_t e2;
  always begin
    @(negedge clk);
    #2;
    if (mon2) begin
      if (q2.size() > 0 && q2[0].cyc == cyc) e2 = q2.pop_front();
      else e2 = '{cyc: cyc, clr: 1'b0, vld: 1'b0, a: 1'b0, b: 1'b0, last: 1'b0};
      chk("w2_outputs", {ser_clear2, ser_valid2, ser_a2, ser_b2, ser_last2, busy2},
          {e2.clr, e2.vld, e2.a, e2.b, e2.last, e2.clr | e2.vld});
      chk("w2_in_ready", in_ready2, !rst2 && (!(e2.clr | e2.vld) || e2.last));
    end
  end

  initial begin
    bit g; int t1, t2;
    rst2 = 1'b1; in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
    repeat (3) drive2(1'b0, 2'b00, 2'b00, 1'b1, g, t1);
    mon2 = 1'b1;
    send2(2'b10, 2'b01, t1);
    send2(2'b01, 2'b01, t2);
    chk("w2_period", t2 - t1, 3);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) drive2(1'b0, W2'($urandom), W2'($urandom), 1'b0, g, t1);
      else drive2(1'b1, W2'($urandom), W2'($urandom), 1'b0, g, t1);
    end
    repeat (5) drive2(1'b0, 2'b00, 2'b00, 1'b0, g, t1);
    chk("w2_queue_empty", q2.size(), 0);
    done2 = 1'b1;
  end

  // ---------------- 8-bit scenario sequence ----------------
  initial begin
    bit g; int t, t1, t2, tt;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) drive8(1'b0, 8'h00, 8'h00, 1'b1, g, t);
    mon8 = 1'b1;

    send8(8'hA5, 8'h5A, t); drain8();
    send8(8'h3C, 8'h3C, t); drain8();

    send8(8'h01, 8'h80, t1);
    send8(8'hFF, 8'hFE, t2);
    chk("b2b_period", t2 - t1, 9);
    drain8();

    // in_a/in_b churn every cycle; only values on in_ready cycles may appear
    for (int i = 0; i < 10; i++) drive8(1'b1, W'($urandom), W'($urandom), 1'b0, g, t);
    drain8();

    // reset during the 4th SHIFT cycle abandons the word
    send8(8'hC3, 8'h3C, t);
    do idle8(); while (cyc < t + 3);
    drive8(1'b1, 8'h55, 8'hAA, 1'b1, g, tt);
    idle8();
    send8(8'h10, 8'h20, t); drain8();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) idle8();
      if ($urandom_range(0, 1) == 1) send8(W'($urandom), W'($urandom), t);
      else drive8(1'b1, W'($urandom), W'($urandom), 1'b0, g, t);
    end
    drain8();
    chk("q8_empty", q8.size(), 0);

    for (int i = 0; i < 500 && !done2; i++) @(negedge clk);
    checks++;
    if (!done2) begin
      errors++;
      $display("FAIL w2_done_timeout: 2-bit sequence did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
